// File: rtl/register_array_burst_loader.sv
// register_array_burst_loader
//    Converts a burst command (start register + word count) and a stream of
//    data words into one-hot per-register write enables and replicated packed
//    write data for a banked register array.  Register index wraps at COUNT-1.
//
// Ports
//    clock       system clock, rising edge
//    reset_n     asynchronous active-low reset
//    cmd_valid   command offered         cmd_ready   loader idle, will accept
//    cmd_base    first register index    cmd_len     words in the burst
//    data_valid  data word offered       data_ready  word accepted this cycle
//    data_in     data word               abort       terminate current burst
//    wren        one-hot write enable (registered)
//    in          packed write data, data_in replicated per slice (registered)
//    busy        burst in progress
//    done        one-cycle pulse, burst completed normally
//    error       one-cycle pulse, command rejected (base out of range)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command; data channel closed
// BURST | accepting data words until the remaining count hits zero or abort
module register_array_burst_loader #(
   parameter int COUNT      = 8,
   parameter int WIDTH      = 36,
   parameter int ADDR_WIDTH = 3,
   parameter int LEN_WIDTH  = 4,
   localparam int TOTAL_WIDTH = COUNT * WIDTH
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_WIDTH-1:0]  cmd_base,
   input  logic [LEN_WIDTH-1:0]   cmd_len,
   input  logic                   data_valid,
   output logic                   data_ready,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   abort,
   output logic [COUNT-1:0]       wren,
   output logic [TOTAL_WIDTH-1:0] in,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]    rem_q, rem_d;
   logic [COUNT-1:0]        wren_d;
   logic [TOTAL_WIDTH-1:0]  in_d;
   logic                    done_d, error_d;

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q == BURST);
   assign data_ready = (state_q == BURST) & ~abort;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         wren    <= '0;
         in      <= '0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         wren    <= wren_d;
         in      <= in_d;
         done    <= done_d;
         error   <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      wren_d  = '0;
      in_d    = in;
      done_d  = 1'b0;
      error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (int'(cmd_base) >= COUNT) begin
                  error_d = 1'b1;
               end else if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  ptr_d   = cmd_base;
                  // a burst longer than the array would only rewrite registers
                  rem_d   = (int'(cmd_len) > COUNT) ? LEN_WIDTH'(COUNT) : cmd_len;
                  state_d = BURST;
               end
            end
         end
         BURST: begin
            if (abort) begin
               state_d = IDLE;
               ptr_d   = '0;
               rem_d   = '0;
            end else if (data_valid) begin
               wren_d = COUNT'(1) << ptr_q;
               in_d   = {COUNT{data_in}};
               // explicit wrap: COUNT need not be a power of two
               ptr_d  = (ptr_q == ADDR_WIDTH'(COUNT - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - LEN_WIDTH'(1);
               if (rem_q == LEN_WIDTH'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_register_array_burst_loader.sv
module tb_register_array_burst_loader;

   localparam int COUNT = 8;
   localparam int WIDTH = 36;
   localparam int AW    = 4;
   localparam int LW    = 4;

   logic                   clock = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   cmd_valid = 1'b0;
   logic                   cmd_ready;
   logic [AW-1:0]          cmd_base = '0;
   logic [LW-1:0]          cmd_len = '0;
   logic                   data_valid = 1'b0;
   logic                   data_ready;
   logic [WIDTH-1:0]       data_in = '0;
   logic                   abort = 1'b0;
   logic [COUNT-1:0]       wren;
   logic [COUNT*WIDTH-1:0] in;
   logic                   busy, done, error;

   int checks = 0;
   int failures = 0;

   register_array_burst_loader #(
      .COUNT(COUNT), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base(cmd_base), .cmd_len(cmd_len),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .abort(abort), .wren(wren), .in(in),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] slice(input int idx);
      return in[idx*WIDTH +: WIDTH];
   endfunction

   task automatic send_cmd(input int base, input int len);
      cmd_valid = 1'b1;
      cmd_base  = AW'(base);
      cmd_len   = LW'(len);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic word(input logic [WIDTH-1:0] d);
      data_valid = 1'b1;
      data_in    = d;
      tick();
      data_valid = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wren", wren, 0);
      chk("rst_in_zero", (in == '0), 1);
      chk("rst_done", done, 0);

      // basic burst base=2 len=3
      send_cmd(2, 3);
      chk("b1_busy", busy, 1);
      chk("b1_cmd_ready", cmd_ready, 0);
      word(36'h0_0000_000A);
      chk("b1_wren0", wren, 8'h04);
      chk("b1_data0", slice(2), 36'h0_0000_000A);
      chk("b1_done0", done, 0);
      word(36'h0_0000_000B);
      chk("b1_wren1", wren, 8'h08);
      chk("b1_data1", slice(3), 36'h0_0000_000B);
      word(36'h0_0000_000C);
      chk("b1_wren2", wren, 8'h10);
      chk("b1_data2", slice(4), 36'h0_0000_000C);
      chk("b1_done2", done, 1);
      chk("b1_cmd_ready_end", cmd_ready, 1);
      tick();
      chk("b1_wren_after", wren, 0);
      chk("b1_done_after", done, 0);
      chk("b1_in_hold", slice(4), 36'h0_0000_000C);

      // wrap with gaps base=6 len=4
      send_cmd(6, 4);
      word(36'h9_8765_4321);
      chk("wr_wren0", wren, 8'h40);
      chk("wr_data0", slice(6), 36'h9_8765_4321);
      chk("wr_done0", done, 0);
      tick();
      chk("wr_gap0", wren, 0);
      word(36'h1_1111_1111);
      chk("wr_wren1", wren, 8'h80);
      chk("wr_done1", done, 0);
      tick();
      chk("wr_gap1", wren, 0);
      word(36'h2_2222_2222);
      chk("wr_wren2", wren, 8'h01);
      chk("wr_data2", slice(0), 36'h2_2222_2222);
      chk("wr_done2", done, 0);
      tick();
      chk("wr_gap2", wren, 0);
      word(36'hF_FFFF_FFFF);
      chk("wr_wren3", wren, 8'h02);
      chk("wr_data3", slice(1), 36'hF_FFFF_FFFF);
      chk("wr_done3", done, 1);
      tick();
      chk("wr_done_once", done, 0);

      // len=0
      send_cmd(3, 0);
      chk("l0_done", done, 1);
      chk("l0_wren", wren, 0);
      chk("l0_busy", busy, 0);
      tick();
      chk("l0_done_clear", done, 0);

      // len=15 clamped to 8
      send_cmd(0, 15);
      for (int i = 0; i < 8; i++) begin
         word(36'h5_0000_0000 + 36'(i));
         chk($sformatf("cl_wren%0d", i), wren, 64'(1) << i);
         chk($sformatf("cl_data%0d", i), slice(i), 36'h5_0000_0000 + 36'(i));
         chk($sformatf("cl_done%0d", i), done, (i == 7) ? 1 : 0);
      end
      chk("cl_data_ready_idle", data_ready, 0);
      word(36'h7_7777_7777);
      chk("cl_no_ninth", wren, 0);
      chk("cl_busy_end", busy, 0);

      // out-of-range base
      send_cmd(9, 4);
      chk("e9_error", error, 1);
      chk("e9_wren", wren, 0);
      chk("e9_busy", busy, 0);
      chk("e9_done", done, 0);
      tick();
      chk("e9_error_clear", error, 0);
      send_cmd(8, 1);
      chk("e8_error", error, 1);
      chk("e8_busy", busy, 0);
      send_cmd(7, 1);
      chk("e7_no_error", error, 0);
      chk("e7_busy", busy, 1);
      word(36'h3);
      chk("e7_wren", wren, 8'h80);
      chk("e7_done", done, 1);

      // abort on 2nd word
      send_cmd(1, 4);
      word(36'hD1);
      chk("ab_wren0", wren, 8'h02);
      data_valid = 1'b1;
      data_in    = 36'hD2;
      abort      = 1'b1;
      #1;
      chk("ab_data_ready", data_ready, 0);
      tick();
      data_valid = 1'b0;
      abort      = 1'b0;
      chk("ab_wren1", wren, 0);
      chk("ab_done", done, 0);
      chk("ab_busy", busy, 0);
      chk("ab_cmd_ready", cmd_ready, 1);
      tick();
      chk("ab_done_later", done, 0);
      // abort in IDLE is ignored
      abort = 1'b1;
      send_cmd(4, 1);
      abort = 1'b0;
      chk("ab_idle_ignored", busy, 1);
      word(36'h44);
      chk("ab_idle_wren", wren, 8'h10);

      // reset mid-burst
      send_cmd(2, 4);
      word(36'h21);
      chk("rm_wren0", wren, 8'h04);
      data_valid = 1'b1;
      data_in    = 36'h22;
      tick();
      chk("rm_wren1", wren, 8'h08);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rm_wren_async", wren, 0);
      chk("rm_busy_async", busy, 0);
      data_valid = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      chk("rm_cmd_ready", cmd_ready, 1);
      chk("rm_done", done, 0);
      chk("rm_wren_after", wren, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
